// File: rtl/sram_ctrl.sv
// 32-bit CPU word port to 16-bit asynchronous SRAM bridge: two half-word cycles per word, low half first.
// Optional SRAM_CTRL_SKIP_EN: write phases whose half byte-enables are all zero are skipped.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned WADDR_W     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [WADDR_W-1:0] cpu_addr,
    input  logic [3:0]         cpu_be,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_busy,
    inout  wire logic [15:0]   data_sram,
    output logic [WADDR_W:0]   addr2sram,
    output logic               cs,
    output logic               we,
    output logic               oe,
    output logic               ub,
    output logic               lb
);

    localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               wr_q, wr_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               cs_d, we_d, oe_d, ub_d, lb_d;
    logic               drive_q, drive_d;
    logic [15:0]        dout_q, dout_d;
    logic [WADDR_W:0]   addr_n;
    logic               phase_lo, phase_hi, act;
    logic [1:0]         be_half;
    logic               cnt_last;

    assign cnt_last = (cnt == '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    wr_d    = cpu_wr;
                    addr_d  = cpu_addr;
                    be_d    = cpu_be;
                    wdata_d = cpu_wdata;
                    cnt_n   = CNT_LOAD;
`ifdef SRAM_CTRL_SKIP_EN
                    if (!cpu_wr || cpu_be[1:0] != 2'b00)
                        state_n = LO;
                    else if (cpu_be[3:2] != 2'b00)
                        state_n = HI;
                    else
                        state_n = DONE;
`else
                    state_n = LO;
`endif
                end
            end
            LO: begin
                if (cnt_last) begin
`ifdef SRAM_CTRL_SKIP_EN
                    state_n = (wr_q && be_q[3:2] == 2'b00) ? DONE : GAP;
`else
                    state_n = GAP;
`endif
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                state_n = HI;
                cnt_n   = CNT_LOAD;
            end
            HI: begin
                if (cnt_last)
                    state_n = DONE;
                else
                    cnt_n = cnt - CNT_W'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the SRAM pins come straight from flops.
    always_comb begin
        phase_lo = (state_n == LO);
        phase_hi = (state_n == HI);
        act      = phase_lo || phase_hi;
        be_half  = phase_hi ? be_d[3:2] : be_d[1:0];
        cs_d     = !act;
        oe_d     = !(act && !wr_d);
        we_d     = !(act && wr_d && (be_half != 2'b00));
        ub_d     = !(act && (!wr_d || be_half[1]));
        lb_d     = !(act && (!wr_d || be_half[0]));
        drive_d  = act && wr_d;
        dout_d   = phase_hi ? wdata_d[31:16] : wdata_d[15:0];
        addr_n   = act ? {addr_d, phase_hi} : addr2sram;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            cs        <= 1'b1;
            we        <= 1'b1;
            oe        <= 1'b1;
            ub        <= 1'b1;
            lb        <= 1'b1;
            drive_q   <= 1'b0;
            dout_q    <= '0;
            addr2sram <= '0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cs        <= cs_d;
            we        <= we_d;
            oe        <= oe_d;
            ub        <= ub_d;
            lb        <= lb_d;
            drive_q   <= drive_d;
            dout_q    <= dout_d;
            addr2sram <= addr_n;
            if (!wr_q && cnt_last) begin
                if (state == LO)
                    cpu_rdata[15:0] <= data_sram;
                else if (state == HI)
                    cpu_rdata[31:16] <= data_sram;
            end
        end
    end

    assign data_sram = drive_q ? dout_q : 16'bz;
    assign cpu_ready = (state == DONE);
    assign cpu_busy  = (state != IDLE);

endmodule
